// File: rtl/primus_pkg.sv
// primus_pkg: shared types and constants for the primus fetch stage
package primus_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {BOOT, RUN, HALTED} fetch_state_e;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
  } fetch_pkt_t;
endpackage

// File: rtl/primus_fetch_ctrl_if.sv
// primus_fetch_ctrl_if: inst_mem read port plus fetch-to-decode packet handshake
interface primus_fetch_ctrl_if #(parameter int IMEM_AW = 10);
  logic               imem_en_o;
  logic [IMEM_AW-1:0] imem_addr_o;
  logic [31:0]        imem_rdata_i;
  logic               if_valid_o;
  logic               if_ready_i;
  logic [31:0]        if_instr_o;
  logic [31:0]        if_pc_o;
  logic [31:0]        if_npc_o;
  modport master (output imem_en_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o, if_npc_o,
                  input imem_rdata_i, if_ready_i);
  modport slave  (input imem_en_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o, if_npc_o,
                  output imem_rdata_i, if_ready_i);
endinterface

// File: rtl/primus_fetch_skid.sv
// primus_fetch_skid: one-entry fetch packet skid buffer with flush
module primus_fetch_skid
  import primus_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  fetch_pkt_t din_i,
  output logic       valid_o,
  output fetch_pkt_t dout_o
);
  logic       r_valid;
  fetch_pkt_t r_pkt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_pkt   <= '0;
    end else begin
      r_valid <= !flush_i & (push_i | (r_valid & !pop_i));
      if (push_i) r_pkt <= din_i;
    end
  end
  assign valid_o = r_valid;
  assign dout_o  = r_pkt;
endmodule

// File: rtl/primus_fetch_ctrl.sv
// primus_fetch_ctrl: PC sequencer feeding decode from a 1-cycle BRAM; PRIMUS_FETCH_MISALIGN_CHECK_EN traps misaligned redirects
module primus_fetch_ctrl
  import primus_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                halt_i,
  input  logic                redirect_valid_i,
  input  logic [31:0]         redirect_pc_i,
  output logic                fetch_misalign_o,
  primus_fetch_ctrl_if.master bus
);
  fetch_state_e r_state, w_state_d;
  logic [31:0]  r_pc, r_iss_pc, w_redir_pc;
  logic         r_inflight, r_out_valid, w_skid_valid, w_issue, w_fire, w_take;
  logic         w_mis_req, w_mis_d, w_skid_push, w_skid_pop;
  logic [1:0]   w_occ;
  fetch_pkt_t   r_out, w_ret, w_skid_pkt;
  assign w_fire = r_out_valid & bus.if_ready_i;
  assign w_take = !r_out_valid | w_fire;
  assign w_occ  = 2'(r_out_valid) + 2'(w_skid_valid) + 2'(r_inflight);
  assign w_ret  = '{instr: bus.imem_rdata_i, pc: r_iss_pc, npc: r_iss_pc + 32'd4};
`ifdef PRIMUS_FETCH_MISALIGN_CHECK_EN
  logic r_mis;
  assign w_redir_pc = redirect_pc_i;
  assign w_mis_req  = redirect_valid_i & (redirect_pc_i[1:0] != 2'b00);
  assign w_mis_d    = redirect_valid_i ? w_mis_req : r_mis;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_mis <= 1'b0;
    else r_mis <= w_mis_d;
  end
  assign fetch_misalign_o = r_mis;
`else
  assign w_redir_pc       = redirect_pc_i & ~32'd3;
  assign w_mis_req        = 1'b0;
  assign w_mis_d          = 1'b0;
  assign fetch_misalign_o = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= BOOT;
    else r_state <= w_state_d;
  end
  // a pending misalign flag pins the FSM in HALTED until an aligned redirect clears it
  always_comb begin
    w_state_d = r_state;
    if (w_mis_req) w_state_d = HALTED;
    else if (r_state == BOOT) w_state_d = RUN;
    else if (r_state == RUN && halt_i && !r_inflight) w_state_d = HALTED;
    else if (r_state == HALTED && !halt_i && !w_mis_d) w_state_d = RUN;
  end
  always_comb begin
    w_issue         = (r_state == RUN) & !halt_i & !redirect_valid_i & ((w_occ - {1'b0, w_fire}) < 2'd2);
    bus.imem_en_o   = w_issue;
    bus.imem_addr_o = w_issue ? r_pc[IMEM_AW+1:2] : '0;
  end
  assign w_skid_pop  = w_take & w_skid_valid;
  assign w_skid_push = r_inflight & !(w_take & !w_skid_valid);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc        <= RESET_PC;
      r_iss_pc    <= '0;
      r_inflight  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (redirect_valid_i) begin
      r_pc        <= w_redir_pc;
      r_inflight  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc     <= r_pc + 32'd4;
        r_iss_pc <= r_pc;
      end
      if (w_take) begin
        r_out_valid <= w_skid_valid | r_inflight;
        if (w_skid_valid) r_out <= w_skid_pkt;
        else if (r_inflight) r_out <= w_ret;
      end
    end
  end
  primus_fetch_skid u_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_valid_i),
    .push_i  (w_skid_push),
    .pop_i   (w_skid_pop),
    .din_i   (w_ret),
    .valid_o (w_skid_valid),
    .dout_o  (w_skid_pkt)
  );
  assign bus.if_valid_o = r_out_valid;
  assign bus.if_instr_o = r_out_valid ? r_out.instr : NOP_INSTR;
  assign bus.if_pc_o    = r_out.pc;
  assign bus.if_npc_o   = r_out.npc;
endmodule

// File: tb/tb_primus_fetch_ctrl.sv
// tb_primus_fetch_ctrl: directed scenarios plus random traffic against a program-order scoreboard
module tb_primus_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0, rst_n = 1'b0, halt = 1'b0, redir = 1'b0, mis, ok;
  logic [31:0] rpc = '0, exp_pc, exp_iss, last_pc;
  int          n_cmp = 0, n_err = 0, occ, n_acc = 0;
  bit          mon_en = 1'b0;
  primus_fetch_ctrl_if #(.IMEM_AW(10)) bus ();
  primus_fetch_ctrl #(.RESET_PC(32'h0), .IMEM_AW(10)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .halt_i           (halt),
    .redirect_valid_i (redir),
    .redirect_pc_i    (rpc),
    .fetch_misalign_o (mis),
    .bus              (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.imem_en_o) bus.imem_rdata_i <= {22'b0, bus.imem_addr_o};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic init_model();
    exp_pc = 32'h0; exp_iss = 32'h0; occ = 0;
  endtask
  task automatic wait_valid(input string tag);
    ok = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.if_valid_o) begin ok = 1'b1; break; end
    end
    chk(tag, ok, 1);
  endtask
  function automatic logic [31:0] tgt(input logic [31:0] p);
`ifdef PRIMUS_FETCH_MISALIGN_CHECK_EN
    return p;
`else
    return p & ~32'd3;
`endif
  endfunction
  // scoreboard: accepted packets must follow program order from the last redirect target
  always @(negedge clk) if (mon_en && rst_n) begin
    chk("occ_le2", 32'(occ <= 2), 1);
    if (!bus.if_valid_o) chk("nop_idle", bus.if_instr_o, NOP);
    if (halt || redir) chk("blocked_en", 32'(bus.imem_en_o), 0);
    if (bus.if_valid_o && bus.if_ready_i) begin
      chk("pkt_pc", bus.if_pc_o, exp_pc);
      chk("pkt_npc", bus.if_npc_o, exp_pc + 32'd4);
      chk("pkt_instr", bus.if_instr_o, {22'b0, exp_pc[11:2]});
      exp_pc += 32'd4; occ--; n_acc++;
    end
    if (bus.imem_en_o) begin
      chk("iss_addr", 32'(bus.imem_addr_o), {22'b0, exp_iss[11:2]});
      exp_iss += 32'd4; occ++;
    end
    if (redir) begin exp_pc = tgt(rpc); exp_iss = tgt(rpc); occ = 0; end
  end
  initial begin
    bus.if_ready_i = 1'b1;
    repeat (2) cyc();
    chk("rst_valid", 32'(bus.if_valid_o), 0);
    chk("rst_instr", bus.if_instr_o, NOP);
    chk("rst_pc", bus.if_pc_o, 0);
    chk("rst_npc", bus.if_npc_o, 0);
    chk("rst_en", 32'(bus.imem_en_o), 0);
    chk("rst_addr", 32'(bus.imem_addr_o), 0);
    chk("rst_mis", 32'(mis), 0);
    cyc(); rst_n = 1'b1; init_model(); mon_en = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) cyc();
      @(negedge clk);
      chk("boot_valid", 32'(bus.if_valid_o), 32'(k >= 3));
      chk("boot_en", 32'(bus.imem_en_o), 32'(k >= 1));
      if (k >= 3) begin
        chk("boot_pc", bus.if_pc_o, 32'((k - 3) * 4));
        chk("boot_instr", bus.if_instr_o, 32'(k - 3));
      end
    end
    cyc(); bus.if_ready_i = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) cyc();
      @(negedge clk);
      chk("stall_en", 32'(bus.imem_en_o), 0);
      chk("stall_valid", 32'(bus.if_valid_o), 1);
    end
    cyc(); bus.if_ready_i = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) cyc();
      @(negedge clk);
      chk("drain_gapless", 32'(bus.if_valid_o), 1);
    end
    cyc(); bus.if_ready_i = 1'b0;
    repeat (3) cyc();
    redir = 1'b1; rpc = 32'h100;
    @(negedge clk);
    chk("redir_no_issue", 32'(bus.imem_en_o), 0);
    cyc(); redir = 1'b0; bus.if_ready_i = 1'b1;
    wait_valid("redir_timeout");
    chk("redir_pc", bus.if_pc_o, 32'h100);
    chk("redir_npc", bus.if_npc_o, 32'h104);
    chk("redir_instr", bus.if_instr_o, 32'h40);
    cyc(); redir = 1'b1; rpc = 32'hFFFF_FFFC;
    cyc(); redir = 1'b0;
    wait_valid("wrap_timeout");
    chk("wrap_pc", bus.if_pc_o, 32'hFFFF_FFFC);
    chk("wrap_npc", bus.if_npc_o, 32'h0);
    chk("wrap_instr", bus.if_instr_o, 32'h3FF);
    cyc();
    @(negedge clk);
    chk("wrap_next_valid", 32'(bus.if_valid_o), 1);
    chk("wrap_next_pc", bus.if_pc_o, 32'h0);
    repeat (5) cyc();
    halt = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) cyc();
      @(negedge clk);
      chk("halt_en", 32'(bus.imem_en_o), 0);
      chk("halt_valid", 32'(bus.if_valid_o), 32'(j < 2));
      if (j == 1) last_pc = bus.if_pc_o;
    end
    cyc(); halt = 1'b0;
    wait_valid("resume_timeout");
    chk("resume_pc", bus.if_pc_o, last_pc + 32'd4);
`ifdef PRIMUS_FETCH_MISALIGN_CHECK_EN
    cyc(); redir = 1'b1; rpc = 32'h102;
    cyc(); redir = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) cyc();
      @(negedge clk);
      chk("mis_flag", 32'(mis), 1);
      chk("mis_en", 32'(bus.imem_en_o), 0);
      chk("mis_valid", 32'(bus.if_valid_o), 0);
    end
    cyc(); redir = 1'b1; rpc = 32'h200;
    cyc(); redir = 1'b0;
    @(negedge clk);
    chk("mis_clear", 32'(mis), 0);
    wait_valid("mis_timeout");
    chk("mis_pc", bus.if_pc_o, 32'h200);
`endif
    n_acc = 0;
    for (int i = 0; i < 800; i++) begin
      cyc();
      bus.if_ready_i = ($urandom % 4) != 0;
      halt  = ($urandom % 10) == 0;
      redir = ($urandom % 25) == 0;
      rpc   = $urandom & ~32'd3;
    end
    cyc(); redir = 1'b0; halt = 1'b0; bus.if_ready_i = 1'b1;
    repeat (10) cyc();
    chk("rand_progress", 32'(n_acc > 100), 1);
    #2 rst_n = 1'b0; mon_en = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.if_valid_o), 0);
    chk("mid_rst_en", 32'(bus.imem_en_o), 0);
    chk("mid_rst_pc", bus.if_pc_o, 0);
    chk("mid_rst_mis", 32'(mis), 0);
    cyc(); cyc(); rst_n = 1'b1; init_model(); mon_en = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) cyc();
      @(negedge clk);
      chk("reboot_valid", 32'(bus.if_valid_o), 32'(k >= 3));
      if (k == 3) chk("reboot_pc", bus.if_pc_o, 0);
    end
    cyc(); mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
